// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types and width helpers for the regfile write-back scheduler.
//   wbRequest : one pending register write (destination address + data)
//   count_w   : bits needed to hold a count 0..n
//   idx_w     : bits needed to index n entries (at least 1)
package regfileWbPkg;

  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_DATA_W = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wbRequest;

  function automatic int unsigned count_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_wb_fifo.sv
// Circular pending-write queue with multi-pop / multi-push per cycle.
//   pop_n/push_n : entries removed from head / appended at tail this cycle
//   push_data    : pushed entries in age order (slot 0 oldest)
//   count        : registered entry count
//   window       : first NUM_PORTS entries from the head, oldest first
//   ent_valid/ent_addr : per-slot occupancy and address for the pending mask
module wb_fifo
  import regfileWbPkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned NUM_SOURCES = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [count_w(NUM_PORTS)-1:0]  pop_n,
  input  logic [count_w(NUM_SOURCES)-1:0] push_n,
  input  wbRequest                       push_data [NUM_SOURCES],
  output logic [count_w(DEPTH)-1:0]      count,
  output wbRequest                       window [NUM_PORTS],
  output logic [DEPTH-1:0]               ent_valid,
  output logic [WB_ADDR_W-1:0]           ent_addr [DEPTH]
);

  localparam int unsigned CNT_W = count_w(DEPTH);
  localparam int unsigned PTR_W = idx_w(DEPTH);

  wbRequest          mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  int unsigned       rd_i, cnt_i, pop_i, push_i;

  assign rd_i   = 32'(rd_ptr);
  assign cnt_i  = 32'(count);
  assign pop_i  = 32'(pop_n);
  assign push_i = 32'(push_n);

  // Head window, modulo addressing so DEPTH need not be a power of two
  always_comb begin
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      window[k] = '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if ((rd_i + k) % DEPTH == e) window[k] = mem[e];
      end
    end
  end

  // Slot e is live when its distance from the head is below count
  always_comb begin
    ent_valid = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      ent_valid[e] = ((e + DEPTH - rd_i) % DEPTH) < cnt_i;
      ent_addr[e]  = mem[e].addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= PTR_W'((rd_i + pop_i) % DEPTH);
      count  <= CNT_W'(cnt_i + push_i - pop_i);
    end
  end

  // Pushes land after the current tail; slots freed by same-cycle pops may be reused
  always_ff @(posedge clk) begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      for (int unsigned j = 0; j < NUM_SOURCES; j++) begin
        if (j < push_i && (rd_i + cnt_i + j) % DEPTH == e) mem[e] <= push_data[j];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-back scheduler: N request sources onto P write ports,
// queued writes first (oldest first), then new requests in source order.
//   req_valid/addr/data : per-source write requests (source 0 highest priority)
//   req_ready           : combinational accept per source
//   wr_en/addr/data     : registered regfile write ports (higher port wins on clash)
//   pending_mask        : registers with a queued or presented write
//   occupancy           : queue entry count
module regfile_wb_scheduler
  import regfileWbPkg::*;
#(
  parameter int unsigned NUM_SOURCES = 3,
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [NUM_SOURCES-1:0]           req_valid,
  input  logic [NUM_SOURCES*WB_ADDR_W-1:0] req_addr,
  input  logic [NUM_SOURCES*WB_DATA_W-1:0] req_data,
  output logic [NUM_SOURCES-1:0]           req_ready,
  output logic [NUM_PORTS-1:0]             wr_en,
  output logic [NUM_PORTS*WB_ADDR_W-1:0]   wr_addr,
  output logic [NUM_PORTS*WB_DATA_W-1:0]   wr_data,
  output logic [(2**WB_ADDR_W)-1:0]        pending_mask,
  output logic [count_w(DEPTH)-1:0]        occupancy
);

  localparam int unsigned CNT_W  = count_w(DEPTH);
  localparam int unsigned POP_W  = count_w(NUM_PORTS);
  localparam int unsigned PUSH_W = count_w(NUM_SOURCES);

  logic [CNT_W-1:0]     q_count;
  wbRequest             q_window [NUM_PORTS];
  logic [DEPTH-1:0]     q_ent_valid;
  logic [WB_ADDR_W-1:0] q_ent_addr [DEPTH];
  logic [POP_W-1:0]     pop_n;
  logic [PUSH_W-1:0]    push_n;
  wbRequest             push_data [NUM_SOURCES];
  logic [NUM_PORTS-1:0] wr_en_d;
  wbRequest             wr_d [NUM_PORTS];

  int unsigned q_cnt, q_issue, free_ports, cap, rank, n_acc, pushes;
  wbRequest    src;
  logic        nz;

  wb_fifo #(
    .DEPTH       (DEPTH),
    .NUM_PORTS   (NUM_PORTS),
    .NUM_SOURCES (NUM_SOURCES)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .pop_n     (pop_n),
    .push_n    (push_n),
    .push_data (push_data),
    .count     (q_count),
    .window    (q_window),
    .ent_valid (q_ent_valid),
    .ent_addr  (q_ent_addr)
  );

  // Acceptance, port allocation and queue push selection
  always_comb begin
    req_ready = '0;
    wr_en_d   = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) wr_d[p] = '0;
    for (int unsigned j = 0; j < NUM_SOURCES; j++) push_data[j] = '0;
    rank  = 0;
    n_acc = 0;
    src   = '0;
    nz    = 1'b0;

    q_cnt      = 32'(q_count);
    q_issue    = (q_cnt < NUM_PORTS) ? q_cnt : NUM_PORTS;
    free_ports = NUM_PORTS - q_issue;
    cap        = free_ports + DEPTH - q_cnt + q_issue;

    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (p < q_issue) begin
        wr_en_d[p] = 1'b1;
        wr_d[p]    = q_window[p];
      end
    end

    // rank counts every lower-priority-index live request, accepted or not
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      src.addr     = req_addr[i*WB_ADDR_W +: WB_ADDR_W];
      src.data     = req_data[i*WB_DATA_W +: WB_DATA_W];
      nz           = (src.addr != '0);
      req_ready[i] = enable && (!nz || rank < cap);
      if (req_valid[i] && nz) begin
        if (req_ready[i]) begin
          for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (p == q_issue + n_acc) begin
              wr_en_d[p] = 1'b1;
              wr_d[p]    = src;
            end
          end
          for (int unsigned j = 0; j < NUM_SOURCES; j++) begin
            if (j + free_ports == n_acc) push_data[j] = src;
          end
          n_acc = n_acc + 1;
        end
        rank = rank + 1;
      end
    end

    pushes = (n_acc > free_ports) ? n_acc - free_ports : 0;
    pop_n  = POP_W'(q_issue);
    push_n = PUSH_W'(pushes);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= wr_en_d;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        wr_addr[p*WB_ADDR_W +: WB_ADDR_W] <= wr_d[p].addr;
        wr_data[p*WB_DATA_W +: WB_DATA_W] <= wr_d[p].data;
      end
    end
  end

  // Mask built only from registered state so dependent-read stalls are glitch-free
  always_comb begin
    pending_mask = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (q_ent_valid[e]) pending_mask[q_ent_addr[e]] = 1'b1;
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (wr_en[p]) pending_mask[wr_addr[p*WB_ADDR_W +: WB_ADDR_W]] = 1'b1;
    end
  end

  assign occupancy = q_count;

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Parametrised register-file write-back scheduler for the cpu32e2 controller; generalises the fixed regfile B port select into N write-request sources onto P regfile write ports. Each cycle it issues queued writes oldest-first, then new requests in fixed source priority. Requests that find no free port are buffered in a DEPTH-entry queue. It exports a pending-write mask so the controller can stall dependent reads.

## Interface
- NUM_SOURCES, 3, write-request channels; index 0 is highest priority (e.g. 0 = mul/div high result, 1 = load data, 2 = base-register update).
- NUM_PORTS, 2, regfile write ports.
- DEPTH, 4, pending-write queue entries (≥1).
- ADDR_W, 5, register address width.
- DATA_W, 32, data width.
- clk  in  1  clock; reset is asynchronous, active-high, named reset.
- reset  in  1  async active-high reset.
- enable  in  1  pipeline advance; low blocks new acceptance only.
- req_valid  in  NUM_SOURCES  write request per source.
- req_addr  in  NUM_SOURCES×ADDR_W  destination register.
- req_data  in  NUM_SOURCES×DATA_W  write data.
- req_ready  out  NUM_SOURCES  request accepted this cycle (combinational).
- wr_en  out  NUM_PORTS  regfile write enable, registered.
- wr_addr  out  NUM_PORTS×ADDR_W  registered.
- wr_data  out  NUM_PORTS×DATA_W  registered.
- pending_mask  out  2^ADDR_W  bit r set when a write to r is queued or in the output register.
- occupancy  out  clog2(DEPTH+1)  queue entry count.

## Operation
- Per cycle: q_issue = min(count, NUM_PORTS). Queue head entries go to ports 0..q_issue-1 in age order.
- cap = (NUM_PORTS − q_issue) + (DEPTH − count + q_issue).
- rank_i = number of lower-index sources with valid and addr≠0.
- req_ready[i] = enable && (addr_i==0 || rank_i < cap).
  - req_ready does not depend on the source's own valid.
  - It does depend on lower sources' valid/addr.
- Accepted nonzero-addr requests, in index order, fill the remaining ports first; the rest push to the queue tail.
- Same-cycle push and pop are legal; occupancy = count − q_issue + pushes.
- Writes to r0 are accepted and discarded: never queued, never issued, never set mask bits.
- Ordering: port assignment is strictly age-ascending (queue, then source 0..N−1). When two ports target the same register in one cycle, the higher-index port's data is final. The regfile must honour this priority.
- enable low: req_ready all 0, no pushes; the queue continues to drain.
- Reset (including mid-operation): queue emptied, wr_en=0, wr_addr=0, wr_data=0, pending_mask=0, occupancy=0. Queued writes are lost by design.

## Timing
- Accepted request issued directly: appears on wr_* at cycle t+1.
- Request queued behind k entries: issues at t+1+floor(k/NUM_PORTS) or later.
- pending_mask is derived from registered state only (queue contents plus the wr_en/wr_addr register). Its bit clears the cycle after the write is presented on wr_*.
- Full queue with no drain: cap = NUM_PORTS. With NUM_PORTS ports busy from the queue, cap = DEPTH − count + q_issue.
- Pointers are circular, wrapping modulo DEPTH; DEPTH need not be a power of two.

## Structure
- Package regfileWbPkg holds:
  - typedef wbRequest {addr, data};
  - count/rank width helper functions.
- Sub-module wb_fifo: circular buffer with up to NUM_PORTS pops and NUM_SOURCES pushes per cycle. It exposes count and a read window of the first NUM_PORTS entries, plus per-entry valid/addr for the mask.
- Top level holds the ready/rank logic, port allocation, output register and mask OR-reduction.

## Test plan
- Single request: source 1 writes r7=0xDEADBEEF, idle queue → ready[1]=1; at t+1 wr_en[0]=1, wr_addr[0]=7; pending_mask[7] high exactly one cycle.
- Overflow: 3 sources valid (r1,r2,r3), empty queue, defaults → all ready. r1→port0, r2→port1, r3 queued (occupancy=1). Next cycle r3 on port0.
- Back-pressure: hold 3 requests every cycle with enable=1 → occupancy saturates at 4. Source 2 then sees ready=0 until a cycle where q_issue frees space. No write is lost or reordered (check by scoreboard).
- r0 and enable: source 0 writes r0 with value 5 → ready=1, no wr_en, mask unchanged. With enable=0 and occupancy=3 → ready all 0, occupancy 3→1→0 over two cycles.
- Same-register hazard: queued r4=0x11 and new r4=0x22 in one cycle → port0=0x11, port1=0x22; the final regfile value is 0x22.
- Reset mid-operation: assert reset with occupancy=4 → next sampled outputs all zero. A post-reset request issues at t+1 normally.
